// File: rtl/multdiv_seq.sv
// Sequential 32-bit signed multiply/divide: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, 32 iterations each, sign fixed at the end.
module multdiv_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state;
  logic [4:0]  count;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mag;
  logic        neg;

  logic        startMul, startDiv, startBoth;
  logic [31:0] magA, magB;
  logic [32:0] addSum;
  logic [63:0] prodNext, prodSigned;
  logic [32:0] shifted, diff;
  logic [31:0] remNext, quoNext, quoSigned;
  logic        prodOvf;

  assign startMul  = ctrl_MULT & ~ctrl_DIV;
  assign startDiv  = ctrl_DIV & ~ctrl_MULT;
  assign startBoth = ctrl_MULT & ctrl_DIV;

  assign magA = data_operandA[31] ? -data_operandA : data_operandA;
  assign magB = data_operandB[31] ? -data_operandB : data_operandB;

  // Multiply: hi accumulates the multiplicand (mag) while the multiplier in lo shifts out.
  assign addSum     = {1'b0, hi} + {1'b0, (lo[0] ? mag : 32'd0)};
  assign prodNext   = {addSum[32:1], addSum[0], lo[31:1]};
  assign prodSigned = neg ? -prodNext : prodNext;
  assign prodOvf    = ~((&prodSigned[63:31]) | ~(|prodSigned[63:31]));

  // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  assign shifted   = {hi, lo[31]};
  assign diff      = shifted - {1'b0, mag};
  assign remNext   = diff[32] ? shifted[31:0] : diff[31:0];
  assign quoNext   = {lo[30:0], ~diff[32]};
  assign quoSigned = neg ? -quoNext : quoNext;

  // A start pulse takes priority in every state and abandons any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count          <= 5'd0;
      hi             <= 32'd0;
      lo             <= 32'd0;
      mag            <= 32'd0;
      neg            <= 1'b0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (startBoth) begin
      state          <= DONE;
      count          <= 5'd0;
      data_result    <= 32'd0;
      data_exception <= 1'b1;
      data_resultRDY <= 1'b1;
      busy           <= 1'b0;
    end else if (startMul || startDiv) begin
      state          <= startMul ? MUL : DIV;
      count          <= 5'd0;
      hi             <= 32'd0;
      lo             <= startMul ? magB : magA;
      mag            <= startMul ? magA : magB;
      neg            <= data_operandA[31] ^ data_operandB[31];
      data_resultRDY <= 1'b0;
      busy           <= 1'b1;
    end else begin
      case (state)
        MUL: begin
          hi    <= prodNext[63:32];
          lo    <= prodNext[31:0];
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state          <= DONE;
            data_result    <= prodSigned[31:0];
            data_exception <= prodOvf;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
          end
        end
        DIV: begin
          hi    <= remNext;
          lo    <= quoNext;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state          <= DONE;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            // Only -2^31 / -1 yields an unsigned magnitude of 2^31 with a positive sign.
            if (mag == 32'd0) begin
              data_result    <= 32'd0;
              data_exception <= 1'b1;
            end else begin
              data_result    <= quoSigned;
              data_exception <= ~neg & quoNext[31];
            end
          end
        end
        DONE: begin
          state          <= IDLE;
          data_resultRDY <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/multdiv_seq.md
MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 The block SHALL have no parameters; the operand and result width is fixed at 32 bits.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high (ports clock, reset).
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 data_operandA  input  32  signed two's-complement multiplicand or dividend.
REQ-006 data_operandB  input  32  signed two's-complement multiplier or divisor.
REQ-007 ctrl_MULT  input  1  one-cycle start pulse for a multiply.
REQ-008 ctrl_DIV  input  1  one-cycle start pulse for a divide.
REQ-009 data_result  output  32  low 32 bits of the product, or the quotient.
REQ-010 data_exception  output  1  overflow or divide-by-zero flag for data_result.
REQ-011 data_resultRDY  output  1  one-cycle pulse marking data_result and data_exception valid.
REQ-012 busy  output  1  high while an operation is in progress.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, MUL, DIV and DONE.
REQ-014 On a clock edge where exactly one of ctrl_MULT or ctrl_DIV is high:
- data_operandA and data_operandB are latched on that edge.
- the iteration counter is set to 0.
- the state becomes MUL or DIV respectively.
- this applies from any state.
REQ-015 A start pulse arriving while in MUL, DIV or DONE SHALL abort the current operation; no data_resultRDY is produced for the aborted operation.
REQ-016 If ctrl_MULT and ctrl_DIV are both high on one edge, the block SHALL enter DONE on that edge and then output data_result=0, data_exception=1.
REQ-017 MUL and DIV SHALL each perform exactly 32 iterations, one per clock, using radix-2 shift-add (multiply) or restoring shift-subtract (divide) on operand magnitudes; the sign is fixed up on the final iteration.
REQ-018 After the 32nd iteration edge the state SHALL be DONE, so that data_resultRDY is high for exactly one cycle, following the 33rd rising edge after the start edge.
REQ-019 DONE SHALL return to IDLE on the next edge unless a new start pulse is present.
REQ-020 busy SHALL be high exactly while the state is MUL or DIV.
REQ-021 Multiply SHALL produce data_result = product[31:0], with data_exception=1 iff the exact signed 64-bit product lies outside [-2^31, 2^31-1].
REQ-022 Divide SHALL produce a signed quotient truncated toward zero; the remainder is discarded.
REQ-023 Divide by zero SHALL produce data_result=0 and data_exception=1 with the normal 33-edge latency.
REQ-024 0x80000000 / 0xFFFFFFFF SHALL produce data_result=0x80000000 and data_exception=1.
REQ-025 data_result and data_exception SHALL update only on entry to DONE, and SHALL hold their values until the next DONE entry or reset.
REQ-026 Operand input changes after the start edge SHALL NOT affect the result.

Reset
REQ-027 When reset is asserted, the block SHALL immediately set the state to IDLE, the counter to 0, all internal registers to 0, and data_result=0, data_exception=0, data_resultRDY=0, busy=0.
REQ-028 Reset asserted mid-operation SHALL abort the operation; no data_resultRDY is produced after reset releases.
REQ-029 A start pulse on the first edge after reset deassertion SHALL be accepted normally.

Verification
REQ-030 MULT with A=7, B=0xFFFFFFFD (-3) -> data_resultRDY is high for one cycle after edge 33, data_result=0xFFFFFFEB, data_exception=0, busy high for edges 1..32.
REQ-031 MULT with A=0x00010000, B=0x00010000 -> data_result=0x00000000, data_exception=1; MULT with A=0x80000000, B=1 -> data_result=0x80000000, data_exception=0.
REQ-032 DIV with A=0xFFFFFFF9 (-7), B=2 -> data_result=0xFFFFFFFD, data_exception=0; DIV with A=5, B=0 -> data_result=0, data_exception=1; DIV with A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_exception=1.
REQ-033 MULT with A=3, B=4, then DIV with A=100, B=7 pulsed 10 edges later -> exactly one data_resultRDY, 33 edges after the DIV pulse, with data_result=14.
REQ-034 Simultaneous ctrl_MULT and ctrl_DIV -> data_resultRDY on the next cycle with data_result=0, data_exception=1.
REQ-035 reset asserted at iteration 20 of a MULT -> all outputs 0 immediately and no data_resultRDY within 40 cycles; a DIV with A=9, B=3 started afterwards -> data_result=3.
